uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
//  Peripheral end of the core's UART write port (uart_dout/uart_we).
//  Each write pushes byte din[7:0] into a FIFO. The FIFO is drained as
//  8N1 serial frames on txd.
//  Sits beside core at SoC top; din/we connect to uart_dout/uart_we, txd goes to the pin.
//  The core has no UART backpressure. Writes that arrive while the FIFO is full are dropped and flagged.
//
// PARAMETERS
//  CLK_DIV   868  clock cycles per bit period (100 MHz / 115200); legal >= 2
//  FIFO_AW   4    FIFO address width; depth = 2**FIFO_AW entries
//
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//  din       in   32  write data from core; only din[7:0] used, [31:8] ignored
//  we        in   1   write strobe, one byte pushed per cycle where we=1
//  txd       out  1   serial output, idle high
//  busy      out  1   1 while a frame is in progress (any state except IDLE)
//  fifo_full out  1   count == 2**FIFO_AW
//  fifo_empty out 1   count == 0
//  overflow  out  1   sticky: a write was dropped since reset
//
// BEHAVIOUR
//  Reset (reset=0, asynchronous) gives:
//   - txd=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0
//   - FIFO pointers/count=0, FSM=IDLE, bit and divider counters=0
//   - a frame in flight is abandoned: txd goes high immediately, no partial stop bit
//  FIFO
//   - circular buffer, read/write pointers FIFO_AW bits wide, wrap naturally
//   - count is FIFO_AW+1 bits wide
//   - push when we=1 and fifo_full=0 (registered flag, start of cycle)
//   - we=1 with fifo_full=1: byte dropped, overflow<=1, even if a pop happens the same cycle
//   - push and pop in the same cycle: count unchanged, both pointers advance
//  FSM (all outputs registered)
//   - IDLE: txd=1. If fifo_empty=0: pop head into shift reg, txd<=0,
//     div<=0, go to START
//   - START: hold txd=0 for CLK_DIV cycles, then txd<=sr[0], bit<=0, go to DATA
//   - DATA: each bit held CLK_DIV cycles, LSB first, shift right. After bit 7,
//     txd<=1, go to STOP
//   - STOP: hold txd=1 for CLK_DIV cycles. At end:
//       - FIFO non-empty: pop next byte, txd<=0, go straight to START
//         (no idle cycle between frames)
//       - else go to IDLE
//  Timing
//   - divider counts 0..CLK_DIV-1; a bit ends when div==CLK_DIV-1
//   - frame length exactly 10*CLK_DIV cycles
//   - latency: we sampled at edge N into an empty FIFO in IDLE gives
//     fifo_empty=0 after N and txd=0 after edge N+1 (start bit at N+2 cycle)
//   - busy=1 from the edge txd falls until the edge the FSM enters IDLE
//  A write to an empty FIFO while a frame is active does not disturb the current frame.
//
// TESTING (CLK_DIV=4, FIFO_AW=2 unless noted)
//  1. Single byte: reset, then we=1 din=32'h0000_0055 for 1 cycle.
//     -> txd low 1 edge later for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each),
//        then high 4 cycles; busy=1 for 40 cycles; fifo_empty back to 1.
//  2. Back-to-back: push 8'hA5 then 8'h3C on consecutive cycles.
//     -> two frames totalling 80 cycles, second start bit immediately after
//        first stop bit, decoded bytes A5, 3C.
//  3. Overflow: push 6 bytes 8'h01..8'h06 on consecutive cycles.
//     -> bytes 01..05 transmitted (one popped into shift reg frees a slot);
//        06 dropped; overflow=1 and stays 1; fifo_full observed 1.
//  4. Full + simultaneous pop: fill FIFO, assert we exactly on the STOP->START
//     pop edge. -> write dropped, overflow=1, count decrements by 1.
//  5. Reset mid-frame: assert reset=0 during DATA bit 3 of 8'hFF.
//     -> txd=1 asynchronously, busy=0, fifo_empty=1.
//     After release with no writes, txd stays high.
//  6. Upper bits ignored: din=32'hDEAD_BE42 -> frame carries 8'h42.
//     Repeat test 1 with CLK_DIV=868; bit period is 868 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide write FIFO drained as 8N1 serial frames on txd.
// Writes into a full FIFO are dropped and latch the sticky overflow flag.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        we,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] CountFull = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overflow_q;

    state_e             state_q;
    logic [DivW-1:0]    div_q;
    logic [2:0]         bit_q;
    logic [7:0]         sr_q;
    logic               txd_q;
    logic               busy_q;

    logic push, pop, bit_end;
    logic unused_din;

    assign unused_din = ^din[31:8];

    assign fifo_full  = (count_q == CountFull);
    assign fifo_empty = (count_q == '0);
    assign bit_end    = (div_q == DivLast);

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign push = we & ~fifo_full;
    assign pop  = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (we && fifo_full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        sr_q    <= mem_q[rptr_q];
                        txd_q   <= 1'b0;
                        div_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        div_q   <= '0;
                        txd_q   <= sr_q[0];
                        bit_q   <= '0;
                        state_q <= StData;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            sr_q  <= {1'b0, sr_q[7:1]};
                            txd_q <= sr_q[1];
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        div_q <= '0;
                        // Chain the next frame with no idle cycle in between.
                        if (pop) begin
                            sr_q    <= mem_q[rptr_q];
                            txd_q   <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int DS    = 868;

    logic        clk;
    logic        reset, we;
    logic [31:0] din;
    logic        txd, busy, fifo_full, fifo_empty, overflow;

    logic        reset_s, we_s;
    logic [31:0] din_s;
    logic        txd_s, busy_s, fifo_full_s, fifo_empty_s, overflow_s;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cycles = 0;

    // Model: pending bytes, plus the frame currently on the wire by elapsed cycle.
    logic [7:0] mq[$];
    bit         m_active;
    logic [7:0] m_byte;
    int         m_pos;
    bit         m_ovf;

    uart_tx_fifo #(.CLK_DIV(D), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .din(din), .we(we), .txd(txd), .busy(busy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
    );

    uart_tx_fifo #(.CLK_DIV(DS), .FIFO_AW(2)) dut_slow (
        .clk(clk), .reset(reset_s), .din(din_s), .we(we_s), .txd(txd_s), .busy(busy_s),
        .fifo_full(fifo_full_s), .fifo_empty(fifo_empty_s), .overflow(overflow_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level for a frame: start bit, 8 data bits LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input int pos, input int d);
        int k;
        k = pos / d;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_pos    = 0;
        m_byte   = '0;
        m_ovf    = 0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] d);
        bit full, empty;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (!m_active) begin
            if (!empty) begin
                m_byte   = mq.pop_front();
                m_active = 1;
                m_pos    = 0;
            end
        end else if (m_pos == 10 * D - 1) begin
            if (!empty) begin
                m_byte = mq.pop_front();
                m_pos  = 0;
            end else begin
                m_active = 0;
            end
        end else begin
            m_pos++;
        end
        if (w) begin
            if (full) m_ovf = 1;
            else mq.push_back(d[7:0]);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_txd;
        exp_txd = m_active ? frame_bit(m_byte, m_pos, D) : 1'b1;
        check({tag, "_txd"}, txd, exp_txd);
        check({tag, "_busy"}, busy, m_active);
        check({tag, "_full"}, fifo_full, mq.size() == DEPTH);
        check({tag, "_empty"}, fifo_empty, mq.size() == 0);
        check({tag, "_ovf"}, overflow, m_ovf);
    endtask

    // Called #1 after a posedge; drives inputs, takes one edge, checks.
    task automatic step(input string tag, input logic w, input logic [31:0] d);
        we  = w;
        din = d;
        @(posedge clk);
        if (reset) model_edge(w, d);
        #1;
        we = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, "_async"});
        @(posedge clk);
        #1;
        check_outputs(tag);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, $urandom);
    endtask

    initial begin
        int guard;
        bit seen_full;
        int rates[6];
        reset   = 1'b0;
        we      = 1'b0;
        din     = '0;
        reset_s = 1'b0;
        we_s    = 1'b0;
        din_s   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst");
        check("rst_slow_txd", txd_s, 1'b1);
        check("rst_slow_empty", fifo_empty_s, 1'b1);
        reset   = 1'b1;
        reset_s = 1'b1;

        // Single byte, upper bits of din ignored via random filler.
        busy_cycles = 0;
        step("t1", 1'b1, 32'h0000_0055);
        drain("t1", 45);
        check("t1_busy_len", busy_cycles, 40);

        // Back-to-back frames.
        busy_cycles = 0;
        step("t2", 1'b1, 32'h0000_00A5);
        step("t2", 1'b1, 32'h0000_003C);
        drain("t2", 85);
        check("t2_busy_len", busy_cycles, 80);

        // Overflow on a burst of six.
        seen_full = 0;
        for (int i = 1; i <= 6; i++) begin
            step("t3", 1'b1, i);
            if (fifo_full === 1'b1) seen_full = 1;
        end
        check("t3_full_seen", seen_full, 1'b1);
        check("t3_ovf", overflow, 1'b1);
        drain("t3", 5 * 10 * D + 10);
        check("t3_ovf_sticky", overflow, 1'b1);

        // Full FIFO with a write on the STOP->START pop edge.
        apply_reset("t4rst");
        for (int i = 0; i < 5; i++) step("t4", 1'b1, 32'h10 + i);
        check("t4_full", fifo_full, 1'b1);
        guard = 0;
        while (!(m_active && m_pos == 10 * D - 1) && guard < 200) begin
            step("t4", 1'b0, 0);
            guard++;
        end
        check("t4_wait", guard < 200, 1'b1);
        step("t4", 1'b1, 32'h99);
        check("t4_ovf", overflow, 1'b1);
        check("t4_not_full", fifo_full, 1'b0);
        drain("t4", 5 * 10 * D + 10);

        // Reset during data bit 3 of 0xFF.
        apply_reset("t5rst");
        step("t5", 1'b1, 32'hFF);
        guard = 0;
        while (!(m_active && m_pos == 4 * D + 1) && guard < 200) begin
            step("t5", 1'b0, 0);
            guard++;
        end
        check("t5_wait", guard < 200, 1'b1);
        check("t5_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("t5_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        drain("t5_idle", 50);

        // Upper 24 bits of din carry no meaning.
        step("t6", 1'b1, 32'hDEAD_BE42);
        drain("t6", 45);

        // Random traffic with varying write density.
        rates = '{3, 10, 30, 60, 95, 20};
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 400; i++) begin
                step("rnd", $urandom_range(0, 99) < rates[s], $urandom);
            end
        end
        drain("rnd_drain", 10 * D * (DEPTH + 1) + 10);

        // Full-rate divider: one frame of 0x55.
        we_s  = 1'b1;
        din_s = 32'hABCD_0055;
        @(posedge clk);
        #1;
        we_s = 1'b0;
        check("slow_not_empty", fifo_empty_s, 1'b0);
        check("slow_idle_txd", txd_s, 1'b1);
        for (int c = 0; c < 10 * DS; c++) begin
            @(posedge clk);
            #1;
            if (txd_s !== frame_bit(8'h55, c, DS)) check("slow_txd", txd_s, frame_bit(8'h55, c, DS));
            if (busy_s !== 1'b1) check("slow_busy", busy_s, 1'b1);
        end
        check("slow_txd_last", txd_s, 1'b1);
        check("slow_empty_mid", fifo_empty_s, 1'b1);
        @(posedge clk);
        #1;
        check("slow_busy_end", busy_s, 1'b0);
        check("slow_txd_end", txd_s, 1'b1);
        check("slow_ovf", overflow_s, 1'b0);
        check("slow_full", fifo_full_s, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
